// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// instruction classes and the datapath mux/trap encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE,
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_AUIPC,
    CL_LUI
  } class_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_IMEM    = 2'd2;
  localparam logic [1:0] TC_DMEM    = 2'd3;

  function automatic logic is_mem_class(class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Memory request handshake between the controller (master) and the
// instruction/data memory port (slave).
interface rv_multicycle_ctrl_if;
  logic imem_req;
  logic dmem_req;
  logic dmem_we;
  logic mem_ready;

  modport master (output imem_req, output dmem_req, output dmem_we, input mem_ready);
  modport slave  (input imem_req, input dmem_req, input dmem_we, output mem_ready);
endinterface

// File: rtl/rv_ctrl_opdecode.sv
// Combinational opcode classifier; flags anything outside the supported RV32I
// subset as illegal.
module rv_ctrl_opdecode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output class_t     op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CL_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_R:      op_class = CL_R;
      OPC_I:      op_class = CL_I;
      OPC_LOAD:   op_class = CL_LOAD;
      OPC_STORE:  op_class = CL_STORE;
      OPC_BRANCH: op_class = CL_BRANCH;
      OPC_JAL:    op_class = CL_JAL;
      OPC_JALR:   op_class = CL_JALR;
      OPC_AUIPC:  op_class = CL_AUIPC;
      OPC_LUI:    op_class = CL_LUI;
      default:    illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: FETCH/DECODE/EXEC/MEM/WB with a
// sticky TRAP for illegal opcodes and memory timeouts, plus an instret counter.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  rv_multicycle_ctrl_if.master mem_if,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic [1:0]           alu_op,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     instret
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  class_t             class_q, class_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  class_t             dec_class;
  logic               dec_illegal;
  logic               timed_out;

  logic               imem_req_c, dmem_req_c, dmem_we_c;
  logic               ir_we_c, pc_we_c, reg_we_c;
  logic [1:0]         pc_src_c, wb_sel_c, alu_op_c;
  logic               alu_a_c, alu_b_c;

  rv_ctrl_opdecode u_opdecode (
    .opcode   (opcode),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  assign timed_out = (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    pc_src_c   = PC_PLUS4;
    wb_sel_c   = WB_ALU;
    alu_op_c   = ALU_ADD;
    alu_a_c    = 1'b0;
    alu_b_c    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (mem_if.mem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (timed_out) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_IMEM;
        end
      end

      ST_DECODE: begin
        class_d = dec_class;
        if (dec_illegal) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (class_q)
          CL_R:     alu_op_c = ALU_RTYPE;
          CL_I: begin
            alu_op_c = ALU_ITYPE;
            alu_b_c  = 1'b1;
          end
          CL_LOAD, CL_STORE: alu_b_c = 1'b1;
          CL_AUIPC: begin
            alu_a_c = 1'b1;
            alu_b_c = 1'b1;
          end
          CL_BRANCH: begin
            alu_op_c = ALU_BRANCH;
            pc_we_c  = 1'b1;
            pc_src_c = branch_taken ? PC_BRANCH : PC_PLUS4;
          end
          default: ;
        endcase
        if (class_q == CL_BRANCH)  state_d = ST_FETCH;
        else if (is_mem_class(class_q)) state_d = ST_MEM;
        else                       state_d = ST_WB;
      end

      ST_MEM: begin
        // Address operands stay on rs1 + imm for the whole access.
        dmem_req_c = 1'b1;
        dmem_we_c  = (class_q == CL_STORE);
        alu_b_c    = 1'b1;
        if (mem_if.mem_ready) begin
          if (class_q == CL_STORE) begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timed_out) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_DMEM;
        end
      end

      ST_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        case (class_q)
          CL_LOAD: wb_sel_c = WB_MEM;
          CL_JAL: begin
            wb_sel_c = WB_PC4;
            pc_src_c = PC_JAL;
          end
          CL_JALR: begin
            wb_sel_c = WB_PC4;
            pc_src_c = PC_JALR;
            alu_b_c  = 1'b1;
          end
          CL_LUI:  wb_sel_c = WB_IMM;
          default: ;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: ;

      default: state_d = ST_FETCH;
    endcase
  end

  // The wait counter restarts on every state change, which covers entry to FETCH and MEM.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_FETCH) || (state_q == ST_MEM)))
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_comb begin
    instret_d = instret_q;
    if (pc_we_c)
      instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      class_q    <= CL_NONE;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= TC_NONE;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      instret_q  <= instret_d;
    end
  end

  // Every output is held low combinationally while reset is asserted.
  always_comb begin
    mem_if.imem_req = rst_n & imem_req_c;
    mem_if.dmem_req = rst_n & dmem_req_c;
    mem_if.dmem_we  = rst_n & dmem_we_c;
    ir_we           = rst_n & ir_we_c;
    pc_we           = rst_n & pc_we_c;
    reg_we          = rst_n & reg_we_c;
    alu_a_sel       = rst_n & alu_a_c;
    alu_b_sel       = rst_n & alu_b_c;
    pc_src          = rst_n ? pc_src_c : '0;
    wb_sel          = rst_n ? wb_sel_c : '0;
    alu_op          = rst_n ? alu_op_c : '0;
    state           = rst_n ? state_q : '0;
    trap            = rst_n & trap_q;
    trap_cause      = rst_n ? cause_q : '0;
    instret         = rst_n ? instret_q : '0;
  end

endmodule
